ant_swarm_draw: RTL and testbench

- Parametrised successor to the single-ant draw sequencer; renders a whole swarm.
- On start, for each active ant it reads X and Y from data memory, then draws a SPRITE×SPRITE block at that position. All accesses go through the shared datapath instruction port.
- Sits between the top-level frame controller and the datapath arbiter. One transaction is outstanding at a time.

---
 rtl/ant_swarm_draw.sv | 245 ++++++++++++++++++++++++
 tb/tb_ant_swarm_draw.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_swarm_draw.sv
`default_nettype none
// ============================================================================
// Module      : ant_swarm_draw
// Description : Swarm draw sequencer. For each active ant it loads X and Y
//               from data memory, then draws a SPRITE x SPRITE block at that
//               position, one datapath transaction outstanding at a time.
// Options     : define ANT_SWARM_CLIP_EN to suppress pixels falling outside
//               SCREEN_W x SCREEN_H (full-width, non-wrapping bound check).
// Ports       : clock, reset (async, active-high)
//               start, ant_count, x_base, y_base, stride, colour  - pass setup
//               busy, done                                        - pass status
//               start_dp, instruction_dp, finished_dp, result_dp  - datapath
// Revision    : 1.0 - initial release
// ============================================================================
module ant_swarm_draw #(
   parameter int MAX_ANTS     = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int RESULT_WIDTH = 16,
   parameter int INSTR_WIDTH  = 32,
   parameter int COORD_WIDTH  = 8,
   parameter int SPRITE       = 2,
   parameter int SCREEN_W     = 160,
   parameter int SCREEN_H     = 120
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic [$clog2(MAX_ANTS+1)-1:0]    ant_count,
   input  logic [ADDR_WIDTH-1:0]            x_base,
   input  logic [ADDR_WIDTH-1:0]            y_base,
   input  logic [ADDR_WIDTH-1:0]            stride,
   input  logic [2:0]                       colour,
   output logic                             busy,
   output logic                             done,
   output logic                             start_dp,
   output logic [INSTR_WIDTH-1:0]           instruction_dp,
   input  logic                             finished_dp,
   input  logic [RESULT_WIDTH-1:0]          result_dp
);

   localparam int c_CNT_W = $clog2(MAX_ANTS+1);
   localparam int c_D_W   = $clog2(SPRITE+1);

   typedef enum logic [3:0] {
      S_IDLE, S_LDX_ISSUE, S_LDX_WAIT, S_LDY_ISSUE, S_LDY_WAIT, S_PIX_CHECK,
      S_DRW_ISSUE, S_DRW_WAIT, S_PIX_NEXT, S_ANT_NEXT, S_DONE
   } state_t;

   state_t                  r_state;
   logic [c_CNT_W-1:0]      r_ant, r_count;
   logic [ADDR_WIDTH-1:0]   r_addr_x, r_addr_y, r_stride;
   logic [2:0]              r_colour;
   logic [COORD_WIDTH-1:0]  r_x, r_y;
   logic [c_D_W-1:0]        r_dx, r_dy;
   logic                    r_armed;   // set after the first WAIT cycle
   logic                    r_busy, r_done, r_start_dp;
   logic [INSTR_WIDTH-1:0]  r_instr;

   logic [c_CNT_W-1:0]      w_count;
   logic [c_CNT_W-1:0]      w_ant_inc;
   logic [ADDR_WIDTH-1:0]   w_addr_x_next, w_addr_y_next;
   logic [COORD_WIDTH-1:0]  w_px, w_py;
   logic [c_D_W-1:0]        w_dx_inc, w_dy_inc;
   logic                    w_skip;
   logic                    w_unused_result;

   assign w_count       = (ant_count > c_CNT_W'(MAX_ANTS)) ? c_CNT_W'(MAX_ANTS) : ant_count;
   assign w_ant_inc     = r_ant + 1'b1;
   assign w_addr_x_next = r_addr_x + r_stride;
   assign w_addr_y_next = r_addr_y + r_stride;
   // Drawn coordinates wrap modulo 2^COORD_WIDTH.
   assign w_px          = r_x + COORD_WIDTH'(r_dx);
   assign w_py          = r_y + COORD_WIDTH'(r_dy);
   assign w_dx_inc      = r_dx + 1'b1;
   assign w_dy_inc      = r_dy + 1'b1;
   assign w_unused_result = ^result_dp[RESULT_WIDTH-1:COORD_WIDTH];

`ifdef ANT_SWARM_CLIP_EN
   // Bound check uses one extra bit so x=255,dx=1 is seen as 256, not 0.
   logic [COORD_WIDTH:0] w_xsum, w_ysum;
   assign w_xsum = {1'b0, r_x} + (COORD_WIDTH+1)'(r_dx);
   assign w_ysum = {1'b0, r_y} + (COORD_WIDTH+1)'(r_dy);
   assign w_skip = (32'(w_xsum) >= 32'(SCREEN_W)) || (32'(w_ysum) >= 32'(SCREEN_H));
`else
   logic w_unused_screen;
   assign w_unused_screen = (SCREEN_W > 0) ^ (SCREEN_H > 0);
   assign w_skip = 1'b0;
`endif

   function automatic logic [INSTR_WIDTH-1:0] f_load(input logic [ADDR_WIDTH-1:0] addr);
      logic [31:0] v;
      v        = 32'(addr);
      v[31:28] = 4'd2;
      return INSTR_WIDTH'(v);
   endfunction

   function automatic logic [INSTR_WIDTH-1:0] f_draw(input logic [COORD_WIDTH-1:0] px,
                                                     input logic [COORD_WIDTH-1:0] py,
                                                     input logic [2:0]             col);
      logic [31:0] v;
      v        = '0;
      v[31:28] = 4'd1;
      v[19]    = 1'b1;
      v[18:16] = col;
      v[15:8]  = 8'(py);
      v[7:0]   = 8'(px);
      return INSTR_WIDTH'(v);
   endfunction

   // Outputs are registered and set on the transition into the state that
   // owns them, so start_dp is high exactly during an ISSUE state and done
   // exactly during DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ant      <= '0;
         r_count    <= '0;
         r_addr_x   <= '0;
         r_addr_y   <= '0;
         r_stride   <= '0;
         r_colour   <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_dx       <= '0;
         r_dy       <= '0;
         r_armed    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_start_dp <= 1'b0;
         r_instr    <= '0;
      end else begin
         r_done     <= 1'b0;
         r_start_dp <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_colour <= colour;
                  r_stride <= stride;
                  r_count  <= w_count;
                  r_ant    <= '0;
                  r_addr_x <= x_base;
                  r_addr_y <= y_base;
                  if (w_count == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_LDX_ISSUE;
                     r_busy     <= 1'b1;
                     r_start_dp <= 1'b1;
                     r_instr    <= f_load(x_base);
                  end
               end
            end
            S_LDX_ISSUE: begin
               r_armed <= 1'b0;
               r_state <= S_LDX_WAIT;
            end
            S_LDX_WAIT: begin
               r_armed <= 1'b1;
               if (r_armed && finished_dp) begin
                  r_x        <= result_dp[COORD_WIDTH-1:0];
                  r_state    <= S_LDY_ISSUE;
                  r_start_dp <= 1'b1;
                  r_instr    <= f_load(r_addr_y);
               end
            end
            S_LDY_ISSUE: begin
               r_armed <= 1'b0;
               r_state <= S_LDY_WAIT;
            end
            S_LDY_WAIT: begin
               r_armed <= 1'b1;
               if (r_armed && finished_dp) begin
                  r_y     <= result_dp[COORD_WIDTH-1:0];
                  r_dx    <= '0;
                  r_dy    <= '0;
                  r_state <= S_PIX_CHECK;
               end
            end
            S_PIX_CHECK: begin
               if (w_skip) begin
                  r_state <= S_PIX_NEXT;
               end else begin
                  r_state    <= S_DRW_ISSUE;
                  r_start_dp <= 1'b1;
                  r_instr    <= f_draw(w_px, w_py, r_colour);
               end
            end
            S_DRW_ISSUE: begin
               r_armed <= 1'b0;
               r_state <= S_DRW_WAIT;
            end
            S_DRW_WAIT: begin
               r_armed <= 1'b1;
               if (r_armed && finished_dp) begin
                  r_state <= S_PIX_NEXT;
               end
            end
            S_PIX_NEXT: begin
               if (w_dx_inc == c_D_W'(SPRITE)) begin
                  r_dx <= '0;
                  if (w_dy_inc == c_D_W'(SPRITE)) begin
                     r_dy    <= '0;
                     r_state <= S_ANT_NEXT;
                  end else begin
                     r_dy    <= w_dy_inc;
                     r_state <= S_PIX_CHECK;
                  end
               end else begin
                  r_dx    <= w_dx_inc;
                  r_state <= S_PIX_CHECK;
               end
            end
            S_ANT_NEXT: begin
               r_ant    <= w_ant_inc;
               r_addr_x <= w_addr_x_next;
               r_addr_y <= w_addr_y_next;
               if (w_ant_inc == r_count) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= S_LDX_ISSUE;
                  r_start_dp <= 1'b1;
                  r_instr    <= f_load(w_addr_x_next);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign start_dp       = r_start_dp;
   assign instruction_dp = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_ant_swarm_draw.sv
`default_nettype none
// ============================================================================
// Module      : tb_ant_swarm_draw
// Description : Directed self-checking bench for ant_swarm_draw with a memory
//               backed datapath model (finished_dp two cycles after start_dp,
//               or held high continuously).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ant_swarm_draw;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  ant_count;
   logic [15:0] x_base, y_base, stride;
   logic [2:0]  colour;
   logic        busy, done, start_dp;
   logic [31:0] instruction_dp;
   logic        finished_dp;
   logic [15:0] result_dp;

   logic [7:0]  mem [256];
   logic        hold_fin;
   logic [1:0]  fin_pipe;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] log_q[$];
   logic [31:0] exp_q[$];
   int          done_cnt, cyc, last_pulse, min_gap;

   ant_swarm_draw #(.MAX_ANTS(4), .SPRITE(2)) dut (
      .clock(clock), .reset(reset), .start(start), .ant_count(ant_count),
      .x_base(x_base), .y_base(y_base), .stride(stride), .colour(colour),
      .busy(busy), .done(done), .start_dp(start_dp),
      .instruction_dp(instruction_dp), .finished_dp(finished_dp),
      .result_dp(result_dp)
   );

   always #5 clock = ~clock;

   assign result_dp   = {8'h00, mem[instruction_dp[7:0]]};
   assign finished_dp = hold_fin | fin_pipe[1];

   always @(posedge clock or posedge reset) begin
      if (reset) fin_pipe <= 2'b00;
      else       fin_pipe <= {fin_pipe[0], start_dp};
   end

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (start_dp) begin
         log_q.push_back(instruction_dp);
         if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
         last_pulse = cyc;
      end
      if (done) done_cnt = done_cnt + 1;
   end

   function automatic logic [31:0] ld(input logic [15:0] a);
      return {4'd2, 12'd0, a};
   endfunction

   function automatic logic [31:0] dr(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
      return {4'd1, 8'd0, 1'b1, c, y, x};
   endfunction

   // Expected sequence for one unclipped ant: two loads then a row-major 2x2 block.
   task automatic exp_ant(input logic [15:0] ax, input logic [15:0] ay,
                          input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
      exp_q.push_back(ld(ax));
      exp_q.push_back(ld(ay));
      exp_q.push_back(dr(x,        y,        c));
      exp_q.push_back(dr(x + 8'd1, y,        c));
      exp_q.push_back(dr(x,        y + 8'd1, c));
      exp_q.push_back(dr(x + 8'd1, y + 8'd1, c));
   endtask

   task automatic run_pass(input logic [2:0] cnt, input logic [15:0] xb, input logic [15:0] yb,
                           input logic [15:0] st, input logic [2:0] col, input int poke_at,
                           output logic busy1);
      int n;
      @(posedge clock);
      log_q.delete();
      done_cnt = 0; last_pulse = -1; min_gap = 1000;
      @(negedge clock);
      ant_count = cnt; x_base = xb; y_base = yb; stride = st; colour = col; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      busy1 = busy;
      if (poke_at > 0) begin
         repeat (poke_at) @(negedge clock);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL pass_timeout: done not seen, got %0d cycles, required < 3000", n);
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; hold_fin = 1'b0;
      ant_count = '0; x_base = '0; y_base = '0; stride = '0; colour = '0;
      repeat (3) @(negedge clock);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
      checks++; if (start_dp !== 1'b0) begin errors++; $display("FAIL reset_start_dp: got %b, required 0", start_dp); end
      checks++; if (instruction_dp !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, required 0", instruction_dp); end
      reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_single;
      logic b;
      mem[8'h10] = 8'd5; mem[8'h20] = 8'd7;
      exp_q.delete();
      exp_ant(16'h10, 16'h20, 8'd5, 8'd7, 3'b011);
      run_pass(3'd1, 16'h10, 16'h20, 16'd2, 3'b011, 0, b);
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", b); end
      checks++; if (log_q.size() != 6) begin errors++; $display("FAIL single_count: got %0d, required 6", log_q.size()); end
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_instr[%0d]: got %h, required %h", i, log_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt); end
   endtask

   task automatic test_multi;
      logic b;
      mem[8'h12] = 8'h30; mem[8'h22] = 8'h40; mem[8'h14] = 8'h50; mem[8'h24] = 8'h60;
      exp_q.delete();
      exp_ant(16'h10, 16'h20, 8'd5,  8'd7,  3'd5);
      exp_ant(16'h12, 16'h22, 8'h30, 8'h40, 3'd5);
      exp_ant(16'h14, 16'h24, 8'h50, 8'h60, 3'd5);
      // Second start pulse mid-pass must be ignored.
      run_pass(3'd3, 16'h10, 16'h20, 16'd2, 3'd5, 10, b);
      checks++; if (log_q.size() != 18) begin errors++; $display("FAIL multi_count: got %0d, required 18", log_q.size()); end
      for (int i = 0; i < 18 && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_instr[%0d]: got %h, required %h", i, log_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL multi_done: got %0d pulses, required 1", done_cnt); end
   endtask

   task automatic test_clamp;
      logic b;
      mem[8'h16] = 8'h11; mem[8'h26] = 8'h22;
      run_pass(3'd7, 16'h10, 16'h20, 16'd2, 3'd2, 0, b);
      checks++; if (log_q.size() != 24) begin errors++; $display("FAIL clamp_count: got %0d, required 24", log_q.size()); end
      if (log_q.size() >= 21) begin
         checks++; if (log_q[18] !== ld(16'h16)) begin errors++; $display("FAIL clamp_ldx: got %h, required %h", log_q[18], ld(16'h16)); end
         checks++; if (log_q[19] !== ld(16'h26)) begin errors++; $display("FAIL clamp_ldy: got %h, required %h", log_q[19], ld(16'h26)); end
         checks++; if (log_q[20] !== dr(8'h11, 8'h22, 3'd2)) begin errors++; $display("FAIL clamp_draw: got %h, required %h", log_q[20], dr(8'h11, 8'h22, 3'd2)); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL clamp_done: got %0d pulses, required 1", done_cnt); end
   endtask

   task automatic test_zero;
      @(posedge clock);
      log_q.delete(); done_cnt = 0;
      @(negedge clock);
      ant_count = 3'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b, required 0", busy); end
      @(negedge clock);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_low: got %b, required 0", done); end
      repeat (3) @(negedge clock);
      checks++; if (log_q.size() != 0) begin errors++; $display("FAIL zero_no_dp: got %0d requests, required 0", log_q.size()); end
   endtask

   task automatic test_back_to_back;
      logic [5:0] seen;
      logic [5:0] expected;
      expected = 6'b010101;
      @(negedge clock);
      ant_count = 3'd0; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         seen[i] = done;
      end
      start = 1'b0;
      checks++; if (seen !== expected) begin errors++; $display("FAIL b2b_done_pattern: got %b, required %b", seen, expected); end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_stale;
      logic b;
      mem[8'h40] = 8'h21; mem[8'h50] = 8'h31;
      exp_q.delete();
      exp_ant(16'h40, 16'h50, 8'h21, 8'h31, 3'd6);
      hold_fin = 1'b1;
      run_pass(3'd1, 16'h40, 16'h50, 16'd2, 3'd6, 0, b);
      hold_fin = 1'b0;
      checks++; if (min_gap < 3) begin errors++; $display("FAIL stale_gap: got %0d cycles, required >= 3", min_gap); end
      checks++; if (log_q.size() != 6) begin errors++; $display("FAIL stale_count: got %0d, required 6", log_q.size()); end
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL stale_instr[%0d]: got %h, required %h", i, log_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      logic b;
      @(posedge clock);
      log_q.delete(); done_cnt = 0;
      @(negedge clock);
      ant_count = 3'd1; x_base = 16'h10; y_base = 16'h20; stride = 16'd2; colour = 3'd1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (log_q.size() < 3 && n < 200) begin @(posedge clock); n++; end
      checks++; if (n >= 200) begin errors++; $display("FAIL midreset_timeout: got %0d cycles, required < 200", n); end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
      checks++; if (start_dp !== 1'b0) begin errors++; $display("FAIL midreset_start_dp: got %b, required 0", start_dp); end
      checks++; if (instruction_dp !== 32'h0) begin errors++; $display("FAIL midreset_instr: got %h, required 0", instruction_dp); end
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses, required 0", done_cnt); end
      run_pass(3'd1, 16'h10, 16'h20, 16'd2, 3'd1, 0, b);
      checks++; if (log_q.size() != 6) begin errors++; $display("FAIL midreset_rerun_count: got %0d, required 6", log_q.size()); end
      if (log_q.size() >= 3) begin
         checks++; if (log_q[2] !== dr(8'd5, 8'd7, 3'd1)) begin errors++; $display("FAIL midreset_rerun_draw: got %h, required %h", log_q[2], dr(8'd5, 8'd7, 3'd1)); end
      end
   endtask

   task automatic test_edge;
      logic b;
      mem[8'h60] = 8'd159; mem[8'h70] = 8'd119;
      exp_q.delete();
`ifdef ANT_SWARM_CLIP_EN
      exp_q.push_back(ld(16'h60)); exp_q.push_back(ld(16'h70));
      exp_q.push_back(dr(8'd159, 8'd119, 3'd7));
`else
      exp_ant(16'h60, 16'h70, 8'd159, 8'd119, 3'd7);
`endif
      run_pass(3'd1, 16'h60, 16'h70, 16'd2, 3'd7, 0, b);
      checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL edge_count: got %0d, required %0d", log_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL edge_instr[%0d]: got %h, required %h", i, log_q[i], exp_q[i]); end
      end
      mem[8'h62] = 8'd255; mem[8'h72] = 8'd10;
      exp_q.delete();
`ifdef ANT_SWARM_CLIP_EN
      exp_q.push_back(ld(16'h62)); exp_q.push_back(ld(16'h72));
`else
      exp_ant(16'h62, 16'h72, 8'd255, 8'd10, 3'd4);
`endif
      run_pass(3'd1, 16'h62, 16'h72, 16'd2, 3'd4, 0, b);
      checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d, required %0d", log_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_instr[%0d]: got %h, required %h", i, log_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; done_cnt = 0; last_pulse = -1; min_gap = 1000;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset;
      test_single;
      test_multi;
      test_clamp;
      test_zero;
      test_back_to_back;
      test_stale;
      test_reset_mid;
      test_edge;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
